// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one external 1-bit full adder to add two
// WIDTH-bit operands LSB first. It latches the operands on start, feeds one
// bit pair plus the stored carry each RUN cycle, collects the sum bits, and
// then presents {cout, sum} with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_next;

    // Shift the new sum bit in at the MSB; a 1-bit adder has nothing to shift.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_next = fa_sum;
        end else begin : g_sum_wn
            assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // The full adder only sees live bits during RUN; it is held quiescent otherwise.
    assign fa_a   = (state == RUN) & a_sh[0];
    assign fa_b   = (state == RUN) & b_sh[0];
    assign fa_cin = (state == RUN) & carry_q;

    // Sequencer: accepts a job in IDLE, processes one bit per RUN cycle, pulses done.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values of its neighbours (the shift chain relies on it).
        if (rst) begin
            // NOTE: the datapath registers are reset too, so an abandoned job
            // leaves no stale bits behind in the shift chain or carry.
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_sh  <= sum_next;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= fa_carry;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= sum_next;
                        cout  <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Any start seen here is dropped; the requester retries in IDLE.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
